pingpong_buffer: RTL and testbench

//  Parametrised double-buffered sample store between a writer (capture side) and a reader (processing side).
//  Two inferred banks of DEPTH x DATA_W. The writer fills one bank while the reader drains the other.

---
 rtl/pingpong_buffer.sv | 171 +++++++++++++++++
 tb/tb_pingpong_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_buffer.sv
// -----------------------------------------------------------------------------
// pingpong_buffer
//
// Double-buffered sample store. It sits between a writer (capture side) and a
// reader (processing side). There are two banks of DEPTH x DATA_W words. The
// writer fills one bank while the reader drains the other. The banks swap when
// both sides are done with them, or when the writer fills its bank and
// AUTO_SWAP is set.
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_reset        synchronous, active-high reset
//   i_rd_addr      read address into the current read bank
//   o_rd_q         read data, one cycle after i_rd_addr
//   i_rd_done      level: reader needs no more reads from its bank
//   i_wr_addr      write address into the current write bank
//   i_wr_data      write data
//   i_wr_en        write strobe
//   i_wr_done      level: writer has finished its bank
//   o_good_to_go   one-cycle pulse: a swap just happened and the new banks are live
//   o_rd_bank      index of the read bank (the write bank is the other one)
//   o_rd_valid     the read bank holds a completed fill
//   o_wr_overrun   sticky: a write was attempted into a frozen bank
//   o_swap_count   number of swaps since reset, wraps around
// -----------------------------------------------------------------------------
module pingpong_buffer #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 9,
   parameter int AUTO_SWAP  = 0,
   parameter int SWAP_CNT_W = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_W-1:0]     i_rd_addr,
   output logic [DATA_W-1:0]     o_rd_q,
   input  logic                  i_rd_done,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0]     i_wr_data,
   input  logic                  i_wr_en,
   input  logic                  i_wr_done,
   output logic                  o_good_to_go,
   output logic                  o_rd_bank,
   output logic                  o_rd_valid,
   output logic                  o_wr_overrun,
   output logic [SWAP_CNT_W-1:0] o_swap_count
);

   localparam int DEPTH   = 2 ** ADDR_W;
   localparam bit AUTO_EN = (AUTO_SWAP != 0);

   typedef enum logic {
      ST_ACTIVE,
      ST_SWAP
   } state_t;

   state_t                r_state;
   logic                  r_rd_bank;
   logic                  r_rd_valid;
   logic                  r_good_to_go;
   logic                  r_wr_overrun;
   logic [SWAP_CNT_W-1:0] r_swap_count;
   logic                  r_auto_latch;

   logic [DATA_W-1:0]     r_bank0 [DEPTH];
   logic [DATA_W-1:0]     r_bank1 [DEPTH];
   logic [DATA_W-1:0]     r_q0;
   logic [DATA_W-1:0]     r_q1;
   logic                  r_rd_sel;

   logic                  w_wr_done_eff;
   logic                  w_swap_req;
   logic                  w_frozen;
   logic                  w_wr_accept;
   logic                  w_wr_bank;
   logic                  w_wr_last;

   // Swap and freeze decisions. They are made only in ACTIVE. A writer that
   // is done but cannot swap yet has a frozen bank: further writes would
   // corrupt a completed fill, so they are dropped and flagged.
   assign w_wr_done_eff = i_wr_done | (AUTO_EN & r_auto_latch);
   assign w_swap_req    = (r_state == ST_ACTIVE) & w_wr_done_eff
                        & (i_rd_done | ~r_rd_valid);
   assign w_frozen      = (r_state == ST_ACTIVE) & w_wr_done_eff & ~w_swap_req;
   assign w_wr_accept   = i_wr_en & ~w_frozen;
   assign w_wr_bank     = ~r_rd_bank;
   assign w_wr_last     = (i_wr_addr == {ADDR_W{1'b1}});

   // Bank storage. Only the current write bank is ever written, so the read
   // bank stays untouched while the reader drains it. The contents are not
   // cleared on reset.
   always_ff @(posedge i_clk) begin
      if (w_wr_accept) begin
         if (w_wr_bank == 1'b0) begin
            r_bank0[i_wr_addr] <= i_wr_data;
         end else begin
            r_bank1[i_wr_addr] <= i_wr_data;
         end
      end
   end

   // Both banks are read every cycle into their own output registers. The
   // bank select is delayed by one cycle alongside the data. A read issued in
   // the cycle before a swap therefore still returns the old bank's word.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q0     <= '0;
         r_q1     <= '0;
         r_rd_sel <= 1'b0;
      end else begin
         r_q0     <= r_bank0[i_rd_addr];
         r_q1     <= r_bank1[i_rd_addr];
         r_rd_sel <= r_rd_bank;
      end
   end

   assign o_rd_q = r_rd_sel ? r_q1 : r_q0;

   // Control FSM. The bank mapping, pulse, validity and counter all change on
   // the edge that enters SWAP, so SWAP already shows the new mapping. The auto
   // latch is cleared on that same edge. A write to the last address during
   // SWAP therefore re-arms it for the new write bank.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_ACTIVE;
         r_rd_bank    <= 1'b1;
         r_rd_valid   <= 1'b0;
         r_good_to_go <= 1'b0;
         r_wr_overrun <= 1'b0;
         r_swap_count <= '0;
         r_auto_latch <= 1'b0;
      end else begin
         if (i_wr_en & w_frozen) begin
            r_wr_overrun <= 1'b1;
         end
         unique case (r_state)
            ST_ACTIVE: begin
               if (w_swap_req) begin
                  r_state      <= ST_SWAP;
                  r_rd_bank    <= ~r_rd_bank;
                  r_good_to_go <= 1'b1;
                  r_rd_valid   <= 1'b1;
                  r_swap_count <= r_swap_count + 1'b1;
                  r_auto_latch <= 1'b0;
               end else begin
                  r_good_to_go <= 1'b0;
                  if (AUTO_EN & w_wr_accept & w_wr_last) begin
                     r_auto_latch <= 1'b1;
                  end
               end
            end
            ST_SWAP: begin
               r_state      <= ST_ACTIVE;
               r_good_to_go <= 1'b0;
               if (AUTO_EN & w_wr_accept & w_wr_last) begin
                  r_auto_latch <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_ACTIVE;
            end
         endcase
      end
   end

   assign o_good_to_go = r_good_to_go;
   assign o_rd_bank    = r_rd_bank;
   assign o_rd_valid   = r_rd_valid;
   assign o_wr_overrun = r_wr_overrun;
   assign o_swap_count = r_swap_count;

endmodule

// File: tb/tb_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// tb_pingpong_buffer
//
// Self-checking bench for pingpong_buffer. The main instance (dut) uses the
// default parameters. The second instance (dutA) has AUTO_SWAP=1 and a
// three-bit swap counter, so its auto-swap path and the counter wrap can be
// reached in a few cycles. Read data goes through a small expected-value
// queue. Swap sequencing is checked against a table of hand-derived vectors.
// -----------------------------------------------------------------------------
module tb_pingpong_buffer;

   logic       clk = 1'b0;
   logic       reset;

   logic [8:0]  rdAddr, wrAddr;
   logic [7:0]  rdQ, wrData;
   logic        rdDone, wrEn, wrDone;
   logic        goodToGo, rdBank, rdValid, wrOverrun;
   logic [15:0] swapCount;

   logic [8:0]  aRdAddr, aWrAddr;
   logic [7:0]  aRdQ, aWrData;
   logic        aRdDone, aWrEn, aWrDone;
   logic        aGoodToGo, aRdBank, aRdValid, aWrOverrun;
   logic [2:0]  aSwapCount;

   int          nVec  = 0;
   int          nMiss = 0;
   logic [7:0]  expQ[$];

   typedef struct {
      logic        wrDone;
      logic        rdDone;
      logic        expGgo;
      logic        expRdBank;
      logic [15:0] expCount;
   } vec_t;

   vec_t vecs[12];

   // Free-running clock for both instances.
   always #5 clk = ~clk;

   pingpong_buffer #(
      .DATA_W(8), .ADDR_W(9), .AUTO_SWAP(0), .SWAP_CNT_W(16)
   ) dut (
      .i_clk(clk), .i_reset(reset),
      .i_rd_addr(rdAddr), .o_rd_q(rdQ), .i_rd_done(rdDone),
      .i_wr_addr(wrAddr), .i_wr_data(wrData), .i_wr_en(wrEn), .i_wr_done(wrDone),
      .o_good_to_go(goodToGo), .o_rd_bank(rdBank), .o_rd_valid(rdValid),
      .o_wr_overrun(wrOverrun), .o_swap_count(swapCount)
   );

   pingpong_buffer #(
      .DATA_W(8), .ADDR_W(9), .AUTO_SWAP(1), .SWAP_CNT_W(3)
   ) dutA (
      .i_clk(clk), .i_reset(reset),
      .i_rd_addr(aRdAddr), .o_rd_q(aRdQ), .i_rd_done(aRdDone),
      .i_wr_addr(aWrAddr), .i_wr_data(aWrData), .i_wr_en(aWrEn), .i_wr_done(aWrDone),
      .o_good_to_go(aGoodToGo), .o_rd_bank(aRdBank), .o_rd_valid(aRdValid),
      .o_wr_overrun(aWrOverrun), .o_swap_count(aSwapCount)
   );

   // Advance one clock and settle just after the edge, away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the write side and the done levels of the main instance.
   task automatic applyStimulus(input logic we, input logic [8:0] wa, input logic [7:0] wd,
                                input logic wdn, input logic rdn);
      wrEn   = we;
      wrAddr = wa;
      wrData = wd;
      wrDone = wdn;
      rdDone = rdn;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue a read on the main instance and queue the expected word. Compare it
   // once the registered data appears one cycle later.
   task automatic issueRead(input logic [8:0] addr, input logic [7:0] exp, input string name);
      rdAddr = addr;
      expQ.push_back(exp);
      tick();
      checkOutput(name, 32'(rdQ), 32'(expQ.pop_front()));
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_rd_bank"},    32'(rdBank),    32'd1);
      checkOutput({tag, "_rd_valid"},   32'(rdValid),   32'd0);
      checkOutput({tag, "_good_to_go"}, 32'(goodToGo),  32'd0);
      checkOutput({tag, "_wr_overrun"}, 32'(wrOverrun), 32'd0);
      checkOutput({tag, "_swap_count"}, 32'(swapCount), 32'd0);
      checkOutput({tag, "_rd_q"},       32'(rdQ),       32'd0);
   endtask

   initial begin
      // Hold both done levels high from ACTIVE with rd_valid=1. A swap is
      // expected every second cycle. Then drop both, and no further swaps.
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd3};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd3};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd4};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd4};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd5};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd5};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd6};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd6};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd7};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd7};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd7};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd7};

      reset  = 1'b1;
      rdAddr = '0;
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
      aRdAddr = '0; aWrAddr = '0; aWrData = '0;
      aWrEn = 1'b0; aWrDone = 1'b0; aRdDone = 1'b0;
      tick();
      tick();
      checkResetState("reset");
      reset = 1'b0;

      // Fill bank 0 with addr ^ A5. The last address must not swap when
      // AUTO_SWAP is off.
      for (int a = 0; a < 512; a++) begin
         applyStimulus(1'b1, 9'(a), 8'(a) ^ 8'hA5, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
      tick();
      checkOutput("no_auto_swap_rd_bank", 32'(rdBank), 32'd1);
      checkOutput("no_auto_swap_valid",   32'(rdValid), 32'd0);

      // Writer done with an empty read side: swap right away.
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
      tick();
      checkOutput("swap1_good_to_go", 32'(goodToGo),  32'd1);
      checkOutput("swap1_rd_bank",    32'(rdBank),    32'd0);
      checkOutput("swap1_rd_valid",   32'(rdValid),   32'd1);
      checkOutput("swap1_count",      32'(swapCount), 32'd1);
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
      tick();
      checkOutput("swap1_pulse_end", 32'(goodToGo),  32'd0);
      checkOutput("swap1_hold_bank", 32'(rdBank),    32'd0);
      checkOutput("swap1_hold_cnt",  32'(swapCount), 32'd1);

      // Read bank 0 while the writer writes the same addresses in bank 1.
      applyStimulus(1'b1, 9'd7, 8'h3C, 1'b0, 1'b0);
      issueRead(9'd7, 8'hA2, "rd7_during_wr");
      applyStimulus(1'b1, 9'd5, 8'h11, 1'b0, 1'b0);
      issueRead(9'd7, 8'hA2, "rd7_after_wr");
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
      issueRead(9'd511, 8'h5A, "rd511");
      issueRead(9'd0,   8'hA5, "rd0");

      // Writer done, reader busy: bank 1 is frozen and the write is dropped.
      applyStimulus(1'b1, 9'd5, 8'h77, 1'b1, 1'b0);
      tick();
      checkOutput("overrun_set",     32'(wrOverrun), 32'd1);
      checkOutput("frozen_no_swap",  32'(goodToGo),  32'd0);
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("overrun_sticky",  32'(wrOverrun), 32'd1);
      checkOutput("frozen_rd_bank",  32'(rdBank),    32'd0);

      // Reader done releases the swap. A read issued in the swap-request cycle
      // still sees the old bank.
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b1, 1'b1);
      issueRead(9'd7, 8'hA2, "rd_before_swap");
      checkOutput("swap2_good_to_go", 32'(goodToGo),  32'd1);
      checkOutput("swap2_rd_bank",    32'(rdBank),    32'd1);
      checkOutput("swap2_overrun",    32'(wrOverrun), 32'd1);
      checkOutput("swap2_count",      32'(swapCount), 32'd2);
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
      issueRead(9'd5, 8'h11, "dropped_write");
      issueRead(9'd7, 8'h3C, "rd_bank1_addr7");

      // Table: continuous swapping with both done levels held.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 9'd0, 8'd0, vecs[i].wrDone, vecs[i].rdDone);
         tick();
         checkOutput($sformatf("vec%0d_good_to_go", i), 32'(goodToGo),  32'(vecs[i].expGgo));
         checkOutput($sformatf("vec%0d_rd_bank", i),    32'(rdBank),    32'(vecs[i].expRdBank));
         checkOutput($sformatf("vec%0d_count", i),      32'(swapCount), 32'(vecs[i].expCount));
      end

      // Reset asserted while in SWAP.
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b1, 1'b1);
      tick();
      checkOutput("pre_reset_swap", 32'(goodToGo), 32'd1);
      applyStimulus(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      checkResetState("midreset");
      reset = 1'b0;
      tick();
      checkOutput("post_reset_idle", 32'(goodToGo), 32'd0);

      // Auto swap on the AUTO_SWAP instance: writing the last address swaps
      // two cycles later without wr_done, and only once.
      aRdDone = 1'b1;
      aWrEn   = 1'b1;
      aWrAddr = 9'd511;
      aWrData = 8'h5E;
      tick();
      aWrEn = 1'b0;
      checkOutput("auto_no_swap_yet", 32'(aGoodToGo), 32'd0);
      checkOutput("auto_rd_bank_pre", 32'(aRdBank),   32'd1);
      tick();
      checkOutput("auto_swap_pulse",  32'(aGoodToGo),  32'd1);
      checkOutput("auto_swap_bank",   32'(aRdBank),    32'd0);
      checkOutput("auto_swap_count",  32'(aSwapCount), 32'd1);
      checkOutput("auto_swap_valid",  32'(aRdValid),   32'd1);
      tick();
      tick();
      checkOutput("auto_latch_clear", 32'(aGoodToGo),  32'd0);
      checkOutput("auto_single_swap", 32'(aSwapCount), 32'd1);
      aRdAddr = 9'd511;
      expQ.push_back(8'h5E);
      tick();
      checkOutput("auto_rd511", 32'(aRdQ), 32'(expQ.pop_front()));

      // Seven more swaps take the three-bit counter from 1 through 7 to 0.
      aWrDone = 1'b1;
      repeat (14) tick();
      aWrDone = 1'b0;
      checkOutput("count_wrap", 32'(aSwapCount), 32'd0);
      checkOutput("auto_overrun_clear", 32'(aWrOverrun), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
